waveform_generator: RTL and testbench
=====================================

# waveform_generator

Parametrised, programmable successor to the basic up/down triangle counter used in the etch-a-sketch datapath. It produces an N-bit triangle, rising sawtooth or falling sawtooth between runtime lower and upper bounds, with a runtime step size. It advances only on enabled cycles and flags every turn-around or wrap with a one-cycle event strobe. It sits between the tick/enable divider and the cursor/DAC consumers.

## Interface
- `N`, 8: output, bound and step width in bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `ena` in 1: advance strobe; when low, all state holds.
- `restart` in 1: synchronous restart to the start point of the selected mode.
- `mode` in 2: 00 triangle, 01 saw up, 10 saw down, 11 freeze (behaves as `ena`=0).
- `lo` in N: lower bound (inclusive).
- `hi` in N: upper bound (inclusive).
- `step` in N: increment magnitude per enabled cycle.
- `out` out N: registered waveform value.
- `dir` out 1: registered direction; 0 = up, 1 = down.
- `evt` out 1: registered one-cycle strobe on turn-around or wrap.

## Operation
- Direction is an explicit registered state, `UP`/`DOWN`. It never depends on combinational decode of `out`.
- Arithmetic is done at N+1 bits, so `out+step` and `out-step` never wrap silently.
- Priority per clock edge, highest first:
  - `restart`
  - `mode`=11 or `ena`=0 (hold)
  - degenerate bounds
  - out-of-range clamp
  - normal step
- `restart`: sets `out`=`lo` and `dir`=UP. In saw-down mode it instead sets `out`=`hi` and `dir`=DOWN. `evt`=0.
- Degenerate bounds (`lo`>=`hi`): `out`<=`lo`, `dir`<=UP, `evt`=0.
- Out-of-range clamp:
  - `out`>`hi`: `out`<=`hi`, `dir`<=DOWN.
  - `out`<`lo`: `out`<=`lo`, `dir`<=UP.
  - `evt`=0 in both cases.
- `step`=0: `out` and `dir` hold, `evt`=0. The clamp and degenerate rules still apply.
- Triangle, state UP:
  - If `out+step` >= `hi`: `out`<=`hi`, `dir`<=DOWN, `evt`=1.
  - Else: `out`<=`out+step`.
- Triangle, state DOWN:
  - If `out` <= `lo+step`: `out`<=`lo`, `dir`<=UP, `evt`=1.
  - Else: `out`<=`out-step`.
- Saw up (`dir` forced to UP):
  - If `out`==`hi`: `out`<=`lo`, `evt`=1.
  - Else: `out`<=min(`out+step`, `hi`).
- Saw down (`dir` forced to DOWN):
  - If `out`==`lo`: `out`<=`hi`, `evt`=1.
  - Else: `out`<=max(`out-step`, `lo`).
- Bounds are always hit exactly. Overshoot is clamped, never skipped.
- Mode changes mid-run take effect on the next enabled edge. `out` is kept, and `dir` is re-forced as described above.
- `lo`/`hi`/`step` are sampled every enabled edge and take no shadow registers. Changes mid-run are legal and are resolved by the clamp rule.

## Timing
- Reset values: `out`=0, `dir`=0 (UP), `evt`=0. State is internal; `mode` selects behaviour.
- After reset with `lo`>0, the first enabled edge clamps to `lo` with no event.
- Latency is one cycle: inputs sampled at edge k are reflected on `out`/`dir`/`evt` after edge k.
- `evt` is high only in the cycle following the edge that loaded the bound or wrap value. It is never high for two consecutive cycles unless two consecutive enabled edges each hit a bound (e.g. `step` >= `hi-lo`).
- `evt` clears on any non-event edge, including hold edges.
- `rst` asserted mid-operation forces reset values immediately, without waiting for `clk`. Release is synchronous to `clk`.
- Defaults `lo`=0, `hi`=2^N-1, `step`=1, triangle, `ena`=1: the sequence is 0,1,…,255,254,…,0,1…, with a period of 510 cycles for N=8. `evt` fires at 255 and at 0.

## Test plan
- **Reset and default triangle.** N=8, `lo`=0, `hi`=255, `step`=1, triangle, `ena`=1 for 1100 cycles.
  - `out` follows 0→255→0.
  - `evt` fires exactly when `out`=255 and when `out`=0 after leaving 0.
  - The period is 510 cycles.
- **Overshoot clamp.** `lo`=10, `hi`=100, `step`=40, triangle.
  - `out` = 10,50,90,100,60,20,10,50.
  - `evt` fires on 100 and on 10; `dir` flips on those cycles.
- **Saw modes.** `lo`=3, `hi`=9, `step`=3.
  - Saw up gives 3,6,9,3,6,9 with `evt` on each 3 after 9.
  - Saw down gives 9,6,3,9 with `evt` on each 9 after 3.
- **Enable and freeze.** Toggle `ena` every other cycle, then set `mode`=11 for 5 cycles.
  - `out` advances only on `ena`=1 edges.
  - `out` is frozen during `mode`=11, and `evt`=0 during holds.
- **Bound changes and degenerate bounds.**
  - With `out`=200, drop `hi` to 50: the next enabled edge gives `out`=50, `dir`=DOWN, `evt`=0.
  - Set `lo`=`hi`=7: `out`=7 and holds.
  - Set `step`=0: `out` holds.
- **Async reset and restart mid-run.**
  - Assert `rst` between edges while `out`=123: `out`=0, `dir`=0, `evt`=0 before the next edge.
  - Pulse `restart` with `ena`=1 in saw-down mode, `lo`=4, `hi`=20: the next value is 20 with `dir`=DOWN.

Source files
------------

// File: rtl/waveform_generator.sv
// Programmable triangle / sawtooth generator between runtime bounds with a runtime step.
// Direction is explicit registered state; evt strobes for one cycle on each turn-around or wrap.
module waveform_generator #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  input  logic         restart_i,
  input  logic [1:0]   mode_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  input  logic [N-1:0] step_i,
  output logic [N-1:0] out_o,
  output logic         dir_o,
  output logic         evt_o
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [1:0] MODE_TRI    = 2'b00;
  localparam logic [1:0] MODE_SAW_UP = 2'b01;
  localparam logic [1:0] MODE_SAW_DN = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  logic [N-1:0] out_q, out_d;
  dir_e         dir_q, dir_d;
  logic         evt_q, evt_d;

  // Widened by one bit so sums against the bounds never wrap.
  logic [N:0]   out_ext, lo_ext, hi_ext, step_ext;
  logic [N:0]   up_sum, lo_plus_step;
  logic [N-1:0] down_diff;

  assign out_ext      = {1'b0, out_q};
  assign lo_ext       = {1'b0, lo_i};
  assign hi_ext       = {1'b0, hi_i};
  assign step_ext     = {1'b0, step_i};
  assign up_sum       = out_ext + step_ext;
  assign lo_plus_step = lo_ext + step_ext;
  // Only consumed when out > lo+step, so it cannot underflow.
  assign down_diff    = out_q - step_i;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    evt_d = 1'b0;
    if (restart_i) begin
      if (mode_i == MODE_SAW_DN) begin
        out_d = hi_i;
        dir_d = DOWN;
      end else begin
        out_d = lo_i;
        dir_d = UP;
      end
    end else if (mode_i == MODE_FREEZE || !ena_i) begin
      out_d = out_q;
    end else if (lo_i >= hi_i) begin
      out_d = lo_i;
      dir_d = UP;
    end else if (out_q > hi_i) begin
      out_d = hi_i;
      dir_d = DOWN;
    end else if (out_q < lo_i) begin
      out_d = lo_i;
      dir_d = UP;
    end else if (step_i != '0) begin
      case (mode_i)
        MODE_TRI: begin
          if (dir_q == UP) begin
            if (up_sum >= hi_ext) begin
              out_d = hi_i;
              dir_d = DOWN;
              evt_d = 1'b1;
            end else begin
              out_d = up_sum[N-1:0];
            end
          end else begin
            if (out_ext <= lo_plus_step) begin
              out_d = lo_i;
              dir_d = UP;
              evt_d = 1'b1;
            end else begin
              out_d = down_diff;
            end
          end
        end
        MODE_SAW_UP: begin
          dir_d = UP;
          if (out_q == hi_i) begin
            out_d = lo_i;
            evt_d = 1'b1;
          end else if (up_sum >= hi_ext) begin
            out_d = hi_i;
          end else begin
            out_d = up_sum[N-1:0];
          end
        end
        default: begin
          dir_d = DOWN;
          if (out_q == lo_i) begin
            out_d = hi_i;
            evt_d = 1'b1;
          end else if (out_ext <= lo_plus_step) begin
            out_d = lo_i;
          end else begin
            out_d = down_diff;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      dir_q <= UP;
      evt_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      evt_q <= evt_d;
    end
  end

  assign out_o = out_q;
  assign dir_o = dir_q;
  assign evt_o = evt_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Self-checking bench for waveform_generator: directed scenarios plus randomized stimulus
// compared every cycle against an integer reference model.
module tb_waveform_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       restart = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] lo = 8'd0;
  logic [7:0] hi = 8'd255;
  logic [7:0] step = 8'd1;
  logic [7:0] out;
  logic       dir;
  logic       evt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_out = 0, m_dir = 0, m_evt = 0;

  waveform_generator #(.N(8)) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .restart_i(restart), .mode_i(mode),
    .lo_i(lo), .hi_i(hi), .step_i(step), .out_o(out), .dir_o(dir), .evt_o(evt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic, evaluated once per rising edge.
  task automatic model_edge();
    int l, h, s, o;
    l = lo; h = hi; s = step; o = m_out;
    m_evt = 0;
    if (rst) begin
      m_out = 0; m_dir = 0;
    end else if (restart) begin
      if (mode == 2'b10) begin m_out = h; m_dir = 1; end
      else begin m_out = l; m_dir = 0; end
    end else if (mode == 2'b11 || !ena) begin
      // hold
    end else if (l >= h) begin
      m_out = l; m_dir = 0;
    end else if (o > h) begin
      m_out = h; m_dir = 1;
    end else if (o < l) begin
      m_out = l; m_dir = 0;
    end else if (s != 0) begin
      if (mode == 2'b00) begin
        if (m_dir == 0) begin
          if (o + s >= h) begin m_out = h; m_dir = 1; m_evt = 1; end
          else m_out = o + s;
        end else begin
          if (o - s <= l) begin m_out = l; m_dir = 0; m_evt = 1; end
          else m_out = o - s;
        end
      end else if (mode == 2'b01) begin
        m_dir = 0;
        if (o == h) begin m_out = l; m_evt = 1; end
        else m_out = (o + s > h) ? h : o + s;
      end else begin
        m_dir = 1;
        if (o == l) begin m_out = h; m_evt = 1; end
        else m_out = (o - s < l) ? l : o - s;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_eq({tag, ".out"}, out, m_out);
    check_eq({tag, ".dir"}, dir, m_dir);
    check_eq({tag, ".evt"}, evt, m_evt);
  endtask

  task automatic set_cfg(input logic [1:0] md, input int l, input int h, input int s);
    mode = md; lo = 8'(l); hi = 8'(h); step = 8'(s);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick(tag);
    restart = 1'b0;
  endtask

  int first_top, period, frozen, adv;
  int ovs_exp[8]  = '{10, 50, 90, 100, 60, 20, 10, 50};
  int ovs_evt[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
  int sup_exp[6]  = '{3, 6, 9, 3, 6, 9};
  int sup_evt[6]  = '{0, 0, 0, 1, 0, 0};
  int sdn_exp[4]  = '{9, 6, 3, 9};
  int sdn_evt[4]  = '{0, 0, 0, 1};

  initial begin
    // Reset and default triangle
    #2;
    check_eq("rst.out", out, 0);
    check_eq("rst.dir", dir, 0);
    check_eq("rst.evt", evt, 0);
    tick("rst_hold");
    rst = 1'b0;
    first_top = -1;
    period = 0;
    for (int i = 0; i < 1100; i++) begin
      tick("tri");
      if (evt && out == 8'd255) begin
        if (first_top < 0) first_top = i;
        else if (period == 0) period = i - first_top;
      end
    end
    check_eq("tri.period", period, 510);
    $display("default triangle: period %0d", period);

    // Overshoot clamp from reset with lo>0
    rst = 1'b1;
    set_cfg(2'b00, 10, 100, 40);
    tick("ovs_rst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick("ovs");
      check_eq("ovs.seq", out, ovs_exp[i]);
      check_eq("ovs.evt_seq", evt, ovs_evt[i]);
      $display("overshoot cycle %0d: out=%0d dir=%0d evt=%0d", i, out, dir, evt);
    end

    // Saw modes
    set_cfg(2'b01, 3, 9, 3);
    do_restart("sup_rs");
    check_eq("sup.seq", out, sup_exp[0]);
    for (int i = 1; i < 6; i++) begin
      tick("sup");
      check_eq("sup.seq", out, sup_exp[i]);
      check_eq("sup.evt_seq", evt, sup_evt[i]);
    end
    set_cfg(2'b10, 3, 9, 3);
    do_restart("sdn_rs");
    check_eq("sdn.seq", out, sdn_exp[0]);
    check_eq("sdn.dir1", dir, 1);
    for (int i = 1; i < 4; i++) begin
      tick("sdn");
      check_eq("sdn.seq", out, sdn_exp[i]);
      check_eq("sdn.evt_seq", evt, sdn_evt[i]);
    end
    $display("saw modes done: out=%0d", out);

    // Enable toggling then freeze
    set_cfg(2'b00, 0, 255, 1);
    do_restart("ena_rs");
    adv = 0;
    for (int i = 0; i < 10; i++) begin
      ena = (i % 2 == 0);
      if (ena) adv++;
      tick("ena");
    end
    check_eq("ena.adv", out, adv);
    ena = 1'b1;
    mode = 2'b11;
    frozen = out;
    for (int i = 0; i < 5; i++) begin
      tick("frz");
      check_eq("frz.out", out, frozen);
      check_eq("frz.evt", evt, 0);
    end
    $display("enable/freeze: advanced %0d, frozen at %0d", adv, frozen);

    // Bound drop, degenerate bounds, zero step
    set_cfg(2'b01, 0, 255, 200);
    do_restart("bnd_rs");
    tick("bnd_200");
    check_eq("bnd.200", out, 200);
    set_cfg(2'b00, 0, 50, 200);
    tick("bnd_drop");
    check_eq("bnd.drop_out", out, 50);
    check_eq("bnd.drop_dir", dir, 1);
    check_eq("bnd.drop_evt", evt, 0);
    set_cfg(2'b00, 7, 7, 3);
    for (int i = 0; i < 3; i++) begin
      tick("degen");
      check_eq("degen.out", out, 7);
    end
    set_cfg(2'b00, 0, 100, 5);
    tick("stp_a");
    tick("stp_b");
    frozen = out;
    step = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick("stp0");
      check_eq("stp0.out", out, frozen);
    end
    $display("bounds: hold value %0d", frozen);

    // Async reset mid-run, then restart in saw-down
    set_cfg(2'b00, 0, 255, 123);
    do_restart("ar_rs");
    tick("ar_123");
    check_eq("ar.123", out, 123);
    #3;
    rst = 1'b1;
    #1;
    check_eq("ar.out", out, 0);
    check_eq("ar.dir", dir, 0);
    check_eq("ar.evt", evt, 0);
    tick("ar_hold");
    rst = 1'b0;
    set_cfg(2'b10, 4, 20, 3);
    do_restart("rsd");
    check_eq("rsd.out", out, 20);
    check_eq("rsd.dir", dir, 1);
    $display("async reset and restart: out=%0d dir=%0d", out, dir);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) mode = 2'($urandom_range(0, 3));
      if (i % 41 == 0) begin
        lo   = 8'($urandom_range(0, 120));
        hi   = 8'($urandom_range(0, 255));
        step = 8'($urandom_range(0, 60));
      end
      ena     = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 63) == 0);
      tick("rnd");
    end
    restart = 1'b0;
    $display("random phase done: out=%0d dir=%0d evt=%0d", out, dir, evt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
